peripheral_arbiter_write_axi4: RTL and testbench
================================================

PERIPHERAL_ARBITER_WRITE_AXI4 -- requirements
Module: peripheral_arbiter_write_axi4

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, write-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, write-data width; strobe width is DATA_WIDTH/8.
REQ-003 aclk  in  1  single clock; all logic on rising edge.
REQ-004 areset  in  1  reset, synchronous, active-high.
REQ-005 m_awadr  in  2*ADDR_WIDTH  master write addresses; master k occupies slice k.
REQ-006 m_awlen  in  2*4  master burst lengths (beats-1).
REQ-007 m_awvalid / m_awready  in / out  2 / 2  per-master AW handshake.
REQ-008 m_wrdata  in  2*DATA_WIDTH  master write data.
REQ-009 m_wstrb  in  2*(DATA_WIDTH/8)  master byte strobes.
REQ-010 m_wlast  in  2  master last-beat flags.
REQ-011 m_wvalid / m_wready  in / out  2 / 2  per-master W handshake.
REQ-012 m_bresp  out  2*2  per-master write response.
REQ-013 m_bvalid / m_bready  out / in  2 / 2  per-master B handshake.
REQ-014 s_awadr, s_awlen, s_awvalid  out  ADDR_WIDTH, 4, 1  shared slave AW channel; s_awready in 1.
REQ-015 s_wrdata, s_wstrb, s_wlast, s_wvalid  out  DATA_WIDTH, DATA_WIDTH/8, 1, 1  shared slave W channel; s_wready in 1.
REQ-016 s_bresp, s_bvalid  in  2, 1  shared slave B channel; s_bready out 1.
REQ-017 grant  out  2  one-hot owner of the slave; 0 when idle.
REQ-018 len_err  out  1  sticky burst-length mismatch flag.

Function
REQ-019 FSM states: IDLE, ADDR, DATA, RESP; exactly one write transaction outstanding at a time.
REQ-020 IDLE: if any m_awvalid, register grant by round-robin (the master not served last wins a tie), go ADDR next cycle; else stay IDLE, grant=0.
REQ-021 ADDR: s_awadr/s_awlen/s_awvalid driven combinationally from granted master; m_awready[g]=s_awready; on s_awvalid&&s_awready latch awlen, clear beat counter, go DATA.
REQ-022 DATA: s_w* from granted master; m_wready[g]=s_wready; each s_wvalid&&s_wready increments a 5-bit beat counter; on handshake with s_wlast=1 go RESP.
REQ-023 RESP: m_bresp[g]=s_bresp, m_bvalid[g]=s_bvalid, s_bready=m_bready[g]; on handshake record g as last-served, go IDLE, grant=0.
REQ-024 Non-granted master: all its ready/valid outputs 0, m_bresp 0; s_awvalid=0 outside ADDR, s_wvalid=0 outside DATA, s_bready=0 outside RESP.
REQ-025 Arbitration latency: first s_awvalid exactly one cycle after m_awvalid seen in IDLE; minimum 1 idle cycle between transactions (RESP->IDLE->ADDR).
REQ-026 len_err SHALL set when wlast handshake beat count (incl. last) != latched awlen+1, or when count reaches awlen+1 without wlast; cleared only by reset; transaction still completes on wlast.
REQ-027 Request withdrawn in ADDR (m_awvalid[g] drops) SHALL not abort; block holds ADDR until handshake.
REQ-028 Both masters requesting continuously SHALL alternate grants 0,1,0,1.

Reset
REQ-029 On areset=1 at a rising edge: state IDLE, grant=0, last-served=1 (master 0 wins first tie), beat counter 0, len_err 0, all valid/ready outputs 0.
REQ-030 Reset mid-transaction SHALL abandon it immediately; no partial response forwarded after reset.

Verification
REQ-031 Single: m0 awadr=0x100, awlen=3, 4 beats, wlast on beat 4, bresp=OKAY -> s_awvalid 1 cycle after request, m_bvalid[0] with bresp 0, grant 01 then 00, len_err 0.
REQ-032 Contention: m0 and m1 both request from reset, awlen=0 -> grant order 01,10,01; m1 ready/valid outputs held 0 while m0 served.
REQ-033 Backpressure: s_awready delayed 3 cycles, s_wready toggling -> s_aw*/s_w* stable while unaccepted, exactly awlen+1 beats forwarded.
REQ-034 Length error: awlen=1, wlast asserted on beat 3 -> len_err=1 from cycle after beat 2, transaction completes, len_err stays 1 until reset.
REQ-035 Reset in DATA after 2 of 4 beats -> next cycle IDLE, grant=0, all handshake outputs 0; new m1 request then served normally.
REQ-036 SLVERR path: slave bresp=2 for m1 -> m_bresp[1]=2, m_bvalid[1] held until m_bready[1].

Source files
------------

// File: rtl/peripheral_arbiter_write_axi4_if.sv
// rtl/peripheral_arbiter_write_axi4_if.sv - two-master write-channel bundle for the write arbiter
interface peripheral_arbiter_write_axi4_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // upstream masters, master k occupies slice k
  logic [2*ADDR_WIDTH-1:0] m_awadr;
  logic [7:0]              m_awlen;
  logic [1:0]              m_awvalid;
  logic [1:0]              m_awready;
  logic [2*DATA_WIDTH-1:0] m_wrdata;
  logic [2*STRB_WIDTH-1:0] m_wstrb;
  logic [1:0]              m_wlast;
  logic [1:0]              m_wvalid;
  logic [1:0]              m_wready;
  logic [3:0]              m_bresp;
  logic [1:0]              m_bvalid;
  logic [1:0]              m_bready;

  // shared downstream slave
  logic [ADDR_WIDTH-1:0]   s_awadr;
  logic [3:0]              s_awlen;
  logic                    s_awvalid;
  logic                    s_awready;
  logic [DATA_WIDTH-1:0]   s_wrdata;
  logic [STRB_WIDTH-1:0]   s_wstrb;
  logic                    s_wlast;
  logic                    s_wvalid;
  logic                    s_wready;
  logic [1:0]              s_bresp;
  logic                    s_bvalid;
  logic                    s_bready;

  // arbitration status
  logic [1:0]              grant;
  logic                    len_err;

  // arbiter view
  modport master (
    input  m_awadr, m_awlen, m_awvalid, m_wrdata, m_wstrb, m_wlast, m_wvalid, m_bready,
    input  s_awready, s_wready, s_bresp, s_bvalid,
    output m_awready, m_wready, m_bresp, m_bvalid,
    output s_awadr, s_awlen, s_awvalid, s_wrdata, s_wstrb, s_wlast, s_wvalid, s_bready,
    output grant, len_err
  );

  // environment view: masters plus slave
  modport slave (
    output m_awadr, m_awlen, m_awvalid, m_wrdata, m_wstrb, m_wlast, m_wvalid, m_bready,
    output s_awready, s_wready, s_bresp, s_bvalid,
    input  m_awready, m_wready, m_bresp, m_bvalid,
    input  s_awadr, s_awlen, s_awvalid, s_wrdata, s_wstrb, s_wlast, s_wvalid, s_bready,
    input  grant, len_err
  );
endinterface

// File: rtl/peripheral_arbiter_write_axi4.sv
// rtl/peripheral_arbiter_write_axi4.sv - round-robin two-master write arbiter, one transaction outstanding
module peripheral_arbiter_write_axi4 #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            aclk,
  input  logic                            areset,
  peripheral_arbiter_write_axi4_if.master bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       last_q, last_d;
  logic [4:0] beat_q, beat_d;
  logic [3:0] len_q, len_d;
  logic       err_q, err_d;

  logic                  g;
  logic                  pick_m1;
  logic [ADDR_WIDTH-1:0] sel_awadr;
  logic [3:0]            sel_awlen;
  logic                  sel_awvalid;
  logic [DATA_WIDTH-1:0] sel_wrdata;
  logic [STRB_WIDTH-1:0] sel_wstrb;
  logic                  sel_wlast;
  logic                  sel_wvalid;
  logic [4:0]            beat_inc;
  logic [4:0]            beat_exp;

  // index of the owning master; only meaningful outside IDLE
  assign g = grant_q[1];

  // on a tie the master that was not served last wins
  assign pick_m1 = (bus.m_awvalid == 2'b11) ? ~last_q : bus.m_awvalid[1];

  assign sel_awadr   = g ? bus.m_awadr[2*ADDR_WIDTH-1:ADDR_WIDTH] : bus.m_awadr[ADDR_WIDTH-1:0];
  assign sel_awlen   = g ? bus.m_awlen[7:4] : bus.m_awlen[3:0];
  assign sel_awvalid = bus.m_awvalid[g];
  assign sel_wrdata  = g ? bus.m_wrdata[2*DATA_WIDTH-1:DATA_WIDTH] : bus.m_wrdata[DATA_WIDTH-1:0];
  assign sel_wstrb   = g ? bus.m_wstrb[2*STRB_WIDTH-1:STRB_WIDTH] : bus.m_wstrb[STRB_WIDTH-1:0];
  assign sel_wlast   = bus.m_wlast[g];
  assign sel_wvalid  = bus.m_wvalid[g];

  // beat count including the beat being accepted, and the count the burst length promises
  assign beat_inc = beat_q + 5'd1;
  assign beat_exp = {1'b0, len_q} + 5'd1;

  assign bus.grant   = grant_q;
  assign bus.len_err = err_q;

  // state and bookkeeping registers; reset abandons any transaction in flight
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      beat_q  <= 5'd0;
      len_q   <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

  // next-state logic and channel routing to/from the granted master
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    beat_d  = beat_q;
    len_d   = len_q;
    err_d   = err_q;

    bus.m_awready = 2'b00;
    bus.m_wready  = 2'b00;
    bus.m_bresp   = 4'b0000;
    bus.m_bvalid  = 2'b00;
    bus.s_awadr   = '0;
    bus.s_awlen   = 4'd0;
    bus.s_awvalid = 1'b0;
    bus.s_wrdata  = '0;
    bus.s_wstrb   = '0;
    bus.s_wlast   = 1'b0;
    bus.s_wvalid  = 1'b0;
    bus.s_bready  = 1'b0;

    case (state_q)
      IDLE: begin
        if (|bus.m_awvalid) begin
          grant_d = pick_m1 ? 2'b10 : 2'b01;
          state_d = ADDR;
        end
      end
      ADDR: begin
        // a withdrawn request just parks here until the address is taken
        bus.s_awadr      = sel_awadr;
        bus.s_awlen      = sel_awlen;
        bus.s_awvalid    = sel_awvalid;
        bus.m_awready[g] = bus.s_awready;
        if (sel_awvalid && bus.s_awready) begin
          len_d   = sel_awlen;
          beat_d  = 5'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        bus.s_wrdata    = sel_wrdata;
        bus.s_wstrb     = sel_wstrb;
        bus.s_wlast     = sel_wlast;
        bus.s_wvalid    = sel_wvalid;
        bus.m_wready[g] = bus.s_wready;
        if (sel_wvalid && bus.s_wready) begin
          beat_d = beat_inc;
          // flag early or late wlast; the burst still ends on wlast
          if (sel_wlast ? (beat_inc != beat_exp) : (beat_inc == beat_exp)) begin
            err_d = 1'b1;
          end
          if (sel_wlast) begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        bus.m_bvalid[g] = bus.s_bvalid;
        if (g) begin
          bus.m_bresp[3:2] = bus.s_bresp;
        end else begin
          bus.m_bresp[1:0] = bus.s_bresp;
        end
        bus.s_bready = bus.m_bready[g];
        if (bus.s_bvalid && bus.m_bready[g]) begin
          last_d  = g;
          grant_d = 2'b00;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_peripheral_arbiter_write_axi4.sv
// tb/tb_peripheral_arbiter_write_axi4.sv - directed vector bench for the two-master write arbiter
module tb_peripheral_arbiter_write_axi4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic aclk = 1'b0;
  logic areset;

  always #5 aclk = ~aclk;

  peripheral_arbiter_write_axi4_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  peripheral_arbiter_write_axi4 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  typedef struct {
    int         mi;
    logic [31:0] adr;
    logic [3:0]  len;
    int         nbeats;
    logic [1:0]  bresp;
    int         aw_delay;
    bit         wtoggle;
    int         bready_delay;
    logic [1:0]  exp_grant;
    logic [1:0]  exp_bresp;
    bit         exp_len_err;
    int         exp_beats;
  } vec_t;

  vec_t vecs [7];

  int n_tests = 0;
  int n_fail  = 0;

  // master/slave model state
  int          req_cnt [2];
  logic [31:0] m_adr [2];
  logic [3:0]  m_len [2];
  int          m_nbeats [2];
  bit          aw_done [2];
  int          sent [2];
  int          bcnt [2];
  logic [1:0]  bresp_log [2];
  bit          b_hold [2];
  logic [1:0]  p_bresp [2];
  int          aw_delay, bready_delay;
  bit          wtoggle;
  logic [1:0]  bresp_cfg;
  int          aw_wait, s_beats, s_cnt, first_aw, last_b;
  bit          s_bpend, model_err;
  logic [1:0]  grant_log [$];
  logic [31:0] adr_log [$];
  logic [3:0]  len_log [$];
  int          gap_log [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] beat_data(input int k, input int b);
    logic [31:0] a;
    a = m_adr[k];
    return {a[15:0], b[15:0]};
  endfunction

  function automatic logic [3:0] beat_strb(input int b);
    return 4'hf ^ b[3:0];
  endfunction

  task automatic clear_inputs();
    bus.m_awadr = '0; bus.m_awlen = '0; bus.m_awvalid = '0;
    bus.m_wrdata = '0; bus.m_wstrb = '0; bus.m_wlast = '0; bus.m_wvalid = '0;
    bus.m_bready = '0;
    bus.s_awready = 1'b0; bus.s_wready = 1'b0; bus.s_bresp = 2'b00; bus.s_bvalid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge aclk);
    areset = 1'b1;
    clear_inputs();
    @(negedge aclk);
    areset = 1'b0;
    model_err = 1'b0;
  endtask

  task automatic eng_init();
    for (int k = 0; k < 2; k++) begin
      req_cnt[k] = 0; aw_done[k] = 0; sent[k] = 0; bcnt[k] = 0;
      bresp_log[k] = 2'b11; b_hold[k] = 0; m_nbeats[k] = 1; p_bresp[k] = 2'b00;
    end
    aw_delay = 0; bready_delay = 0; wtoggle = 0; bresp_cfg = 2'b00;
    aw_wait = 0; s_beats = 0; s_cnt = 0; first_aw = -1; last_b = -1; s_bpend = 0;
    grant_log.delete(); adr_log.delete(); len_log.delete(); gap_log.delete();
  endtask

  // cycle loop: drive masters and slave at negedge, check and record handshakes 1ns later
  task automatic run_engine(input int max_cycles, input int stop_beats, input bit expect_done);
    int          cycle;
    int          g;
    bit          p_aw_stall, p_w_stall;
    logic [31:0] p_awadr, p_wdata;
    logic [3:0]  p_awlen;
    cycle = 0; p_aw_stall = 0; p_w_stall = 0;
    p_awadr = '0; p_wdata = '0; p_awlen = '0;
    while ((req_cnt[0] + req_cnt[1]) > 0 && cycle < max_cycles &&
           !(stop_beats > 0 && s_beats >= stop_beats)) begin
      @(negedge aclk);
      for (int k = 0; k < 2; k++) begin
        bus.m_awvalid[k]        = (req_cnt[k] > 0) && !aw_done[k];
        bus.m_awadr[k*AW +: AW] = m_adr[k];
        bus.m_awlen[k*4 +: 4]   = m_len[k];
        bus.m_wvalid[k]         = (req_cnt[k] > 0) && aw_done[k] && (sent[k] < m_nbeats[k]);
        bus.m_wrdata[k*DW +: DW] = beat_data(k, sent[k]);
        bus.m_wstrb[k*4 +: 4]   = beat_strb(sent[k]);
        bus.m_wlast[k]          = (sent[k] == m_nbeats[k] - 1);
        bus.m_bready[k]         = (bcnt[k] >= bready_delay);
      end
      bus.s_awready = (aw_wait >= aw_delay);
      bus.s_wready  = wtoggle ? cycle[0] : 1'b1;
      bus.s_bvalid  = s_bpend;
      bus.s_bresp   = s_bpend ? bresp_cfg : 2'b00;
      #1;
      check("grant_onehot", ($countones(bus.grant) <= 1), 1);
      for (int k = 0; k < 2; k++) begin
        if (!bus.grant[k])
          check($sformatf("ungranted_m%0d_out", k),
                {bus.m_awready[k], bus.m_wready[k], bus.m_bvalid[k], bus.m_bresp[2*k +: 2]}, 0);
        if (b_hold[k])
          check($sformatf("bvalid_hold_m%0d", k), {bus.m_bvalid[k], bus.m_bresp[2*k +: 2]}, {1'b1, p_bresp[k]});
      end
      if (p_aw_stall) check("aw_stable", {bus.s_awvalid, bus.s_awadr, bus.s_awlen}, {1'b1, p_awadr, p_awlen});
      if (p_w_stall) check("w_stable", {bus.s_wvalid, bus.s_wrdata}, {1'b1, p_wdata});
      check("len_err_track", bus.len_err, model_err);
      if (bus.s_awvalid && first_aw < 0) first_aw = cycle;
      if (bus.s_awvalid && bus.s_awready) begin
        grant_log.push_back(bus.grant);
        adr_log.push_back(bus.s_awadr);
        len_log.push_back(bus.s_awlen);
        if (last_b >= 0) gap_log.push_back(cycle - last_b);
        s_cnt = 0; aw_wait = 0;
      end else if (bus.s_awvalid) begin
        aw_wait++;
      end
      if (bus.s_wvalid && bus.s_wready) begin
        g = aw_done[1] ? 1 : 0;
        check("w_route", {bus.s_wrdata, bus.s_wstrb}, {beat_data(g, sent[g]), beat_strb(sent[g])});
        s_beats++; s_cnt++;
        if (bus.s_wlast ? (s_cnt != int'(m_len[g]) + 1) : (s_cnt == int'(m_len[g]) + 1)) model_err = 1'b1;
        if (bus.s_wlast) s_bpend = 1'b1;
      end
      if (bus.s_bvalid && bus.s_bready) begin
        s_bpend = 1'b0; last_b = cycle;
      end
      for (int k = 0; k < 2; k++) begin
        b_hold[k] = 0;
        if (bus.m_awvalid[k] && bus.m_awready[k]) aw_done[k] = 1;
        if (bus.m_wvalid[k] && bus.m_wready[k]) sent[k]++;
        if (bus.m_bvalid[k]) begin
          if (bus.m_bready[k]) begin
            bresp_log[k] = bus.m_bresp[2*k +: 2];
            req_cnt[k]--; aw_done[k] = 0; sent[k] = 0; bcnt[k] = 0;
          end else begin
            bcnt[k]++; b_hold[k] = 1; p_bresp[k] = bus.m_bresp[2*k +: 2];
          end
        end
      end
      p_aw_stall = bus.s_awvalid && !bus.s_awready;
      p_awadr = bus.s_awadr; p_awlen = bus.s_awlen;
      p_w_stall = bus.s_wvalid && !bus.s_wready;
      p_wdata = bus.s_wrdata;
      cycle++;
    end
    if (expect_done) check("engine_done", req_cnt[0] + req_cnt[1], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //          mi adr           len  nb bresp awd tog brd  grant  bresp err beats
    vecs[0] = '{0, 32'h0000_0100, 4'd3,  4, 2'd0, 0, 1'b0, 0, 2'b01, 2'd0, 1'b0, 4};
    vecs[1] = '{1, 32'h0000_2000, 4'd1,  2, 2'd2, 0, 1'b0, 3, 2'b10, 2'd2, 1'b0, 2};
    vecs[2] = '{0, 32'h0000_0300, 4'd2,  3, 2'd0, 3, 1'b1, 0, 2'b01, 2'd0, 1'b0, 3};
    vecs[3] = '{1, 32'h0000_0440, 4'd1,  3, 2'd0, 0, 1'b0, 0, 2'b10, 2'd0, 1'b1, 3};
    vecs[4] = '{0, 32'h0000_5000, 4'd0,  1, 2'd1, 0, 1'b0, 1, 2'b01, 2'd1, 1'b0, 1};
    vecs[5] = '{1, 32'h0000_0600, 4'd2,  2, 2'd3, 0, 1'b1, 0, 2'b10, 2'd3, 1'b1, 2};
    vecs[6] = '{0, 32'h0000_7000, 4'd15, 16, 2'd0, 1, 1'b0, 0, 2'b01, 2'd0, 1'b0, 16};

    // reset state with every input pushing
    areset = 1'b1;
    clear_inputs();
    bus.m_awvalid = 2'b11; bus.m_wvalid = 2'b11; bus.m_bready = 2'b11;
    bus.s_awready = 1'b1; bus.s_wready = 1'b1; bus.s_bvalid = 1'b1; bus.s_bresp = 2'd2;
    repeat (2) @(negedge aclk);
    #1;
    check("reset_grant_err", {bus.grant, bus.len_err}, 0);
    check("reset_handshake_out",
          {bus.m_awready, bus.m_wready, bus.m_bvalid, bus.m_bresp, bus.s_awvalid, bus.s_wvalid, bus.s_bready}, 0);

    // request withdrawn in ADDR does not abort and blocks the other master
    do_reset();
    eng_init();
    @(negedge aclk);
    bus.m_awadr[31:0] = 32'h500; bus.m_awlen[3:0] = 4'd0; bus.m_awvalid = 2'b01; bus.s_awready = 1'b0;
    @(negedge aclk);
    #1;
    check("wd_addr", {bus.grant, bus.s_awvalid}, {2'b01, 1'b1});
    bus.m_awvalid = 2'b10;
    #1;
    check("wd_drop", bus.s_awvalid, 0);
    repeat (2) begin
      @(negedge aclk);
      #1;
      check("wd_hold", {bus.grant, bus.m_awready}, {2'b01, 2'b00});
    end
    bus.m_awvalid = 2'b00;
    m_adr[0] = 32'h500; m_len[0] = 4'd0; m_nbeats[0] = 1; req_cnt[0] = 1;
    run_engine(100, 0, 1);
    check("wd_naw", grant_log.size(), 1);
    if (grant_log.size() == 1) check("wd_grant_adr", {grant_log[0], adr_log[0]}, {2'b01, 32'h500});

    // contention from reset: grants alternate, one idle cycle between transactions
    do_reset();
    eng_init();
    for (int k = 0; k < 2; k++) begin
      m_len[k] = 4'd0; m_nbeats[k] = 1; req_cnt[k] = 2;
    end
    m_adr[0] = 32'hA000; m_adr[1] = 32'hB000;
    run_engine(200, 0, 1);
    check("rr_naw", grant_log.size(), 4);
    if (grant_log.size() == 4)
      check("rr_order", {grant_log[0], grant_log[1], grant_log[2], grant_log[3]}, 8'b01_10_01_10);
    check("rr_ngap", gap_log.size(), 3);
    foreach (gap_log[i]) check($sformatf("rr_gap%0d", i), gap_log[i], 2);

    // table of single transactions
    for (int i = 0; i < 7; i++) begin
      do_reset();
      eng_init();
      m_adr[vecs[i].mi] = vecs[i].adr;
      m_len[vecs[i].mi] = vecs[i].len;
      m_nbeats[vecs[i].mi] = vecs[i].nbeats;
      req_cnt[vecs[i].mi] = 1;
      aw_delay = vecs[i].aw_delay; wtoggle = vecs[i].wtoggle;
      bready_delay = vecs[i].bready_delay; bresp_cfg = vecs[i].bresp;
      run_engine(300, 0, 1);
      check($sformatf("v%0d_naw", i), grant_log.size(), 1);
      if (grant_log.size() == 1)
        check($sformatf("v%0d_grant_adr_len", i), {grant_log[0], adr_log[0], len_log[0]},
              {vecs[i].exp_grant, vecs[i].adr, vecs[i].len});
      check($sformatf("v%0d_beats", i), s_beats, vecs[i].exp_beats);
      check($sformatf("v%0d_bresp", i), bresp_log[vecs[i].mi], vecs[i].exp_bresp);
      check($sformatf("v%0d_latency", i), first_aw, 1);
      @(negedge aclk);
      clear_inputs();
      #1;
      check($sformatf("v%0d_idle", i), {bus.grant, bus.s_awvalid, bus.s_wvalid, bus.s_bready}, 0);
      check($sformatf("v%0d_len_err", i), bus.len_err, vecs[i].exp_len_err);
    end

    // length error: awlen=1 with wlast on beat 3, flag sticky across a clean transaction
    do_reset();
    eng_init();
    m_adr[0] = 32'hC00; m_len[0] = 4'd1; m_nbeats[0] = 3; req_cnt[0] = 1;
    run_engine(100, 2, 0);
    @(negedge aclk);
    bus.s_wready = 1'b0;
    #1;
    check("lerr_after_beat2", bus.len_err, 1);
    run_engine(100, 0, 1);
    check("lerr_beats", s_beats, 3);
    check("lerr_bresp", bresp_log[0], 0);
    eng_init();
    m_adr[1] = 32'hD00; m_len[1] = 4'd0; m_nbeats[1] = 1; req_cnt[1] = 1;
    run_engine(100, 0, 1);
    @(negedge aclk);
    clear_inputs();
    #1;
    check("lerr_sticky", bus.len_err, 1);

    // reset in DATA after 2 of 4 beats, then a fresh m1 transaction
    do_reset();
    eng_init();
    m_adr[0] = 32'h800; m_len[0] = 4'd3; m_nbeats[0] = 4; req_cnt[0] = 1;
    run_engine(100, 2, 0);
    check("rst_mid_beats", s_beats, 2);
    @(negedge aclk);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    #1;
    check("rst_mid_grant", bus.grant, 0);
    check("rst_mid_outs",
          {bus.m_awready, bus.m_wready, bus.m_bvalid, bus.s_awvalid, bus.s_wvalid, bus.s_bready}, 0);
    @(negedge aclk);
    clear_inputs();
    model_err = 1'b0;
    eng_init();
    m_adr[1] = 32'h900; m_len[1] = 4'd1; m_nbeats[1] = 2; req_cnt[1] = 1;
    run_engine(100, 0, 1);
    check("rst_new_naw", grant_log.size(), 1);
    if (grant_log.size() == 1) check("rst_new_grant", grant_log[0], 2'b10);
    check("rst_new_beats", s_beats, 2);
    check("rst_new_bresp_lat", {bresp_log[1], first_aw[7:0]}, {2'b00, 8'd1});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
